// File: rtl/dijkstra_controller.sv
// -----------------------------------------------------------------------------
// dijkstra_controller
//
// Sequencer for single-source shortest path over a MAX_NODES adjacency matrix.
// It drives one external PriorityQueue, which holds the tentative distances and
// reports the minimum unvisited node. The controller keeps two tables:
//   pred : tentative predecessor of every node, updated while relaxing edges
//   prev : published predecessor of every visited node (UNVISITED otherwise);
//          the queue uses it to leave visited nodes out of its minimum search
//
// Each pop takes one SELECT cycle plus an ADDR/CHECK pair for every column of
// the popped row, giving 1 + 2*MAX_NODES cycles per pop.
//
// Ports
//   clock, reset             rising-edge clock, synchronous active-low reset
//   start, source            run request and source node (taken in IDLE/DONE)
//   busy, done               run in progress / run finished
//   edge_from, edge_to       adjacency read address (row, column)
//   edge_weight              adjacency data, one cycle after the address
//   pq_reset                 loads INFINITY everywhere and 0 at pq_index
//   pq_set_en, pq_index,     queue write strobe, access index, write data
//   pq_write_value
//   pq_read_value            dist[pq_index] from the queue (combinational)
//   pq_min_index/value       queue minimum over unvisited nodes
//   prev_vector_flattened    node j at bits [INDEX_WIDTH*j +: INDEX_WIDTH]
//
// Build option
//   DIJKSTRA_EARLY_EXIT_EN   adds input `target` (taken with start); the run
//                            ends as soon as `target` is popped.
// -----------------------------------------------------------------------------
module dijkstra_controller #(
  parameter int unsigned MAX_NODES   = 8,
  parameter int unsigned INDEX_WIDTH = 4,
  parameter int unsigned VALUE_WIDTH = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [INDEX_WIDTH-1:0]           source,
`ifdef DIJKSTRA_EARLY_EXIT_EN
  input  logic [INDEX_WIDTH-1:0]           target,
`endif
  output logic                             busy,
  output logic                             done,
  output logic [INDEX_WIDTH-1:0]           edge_from,
  output logic [INDEX_WIDTH-1:0]           edge_to,
  input  logic [VALUE_WIDTH-1:0]           edge_weight,
  output logic                             pq_reset,
  output logic                             pq_set_en,
  output logic [INDEX_WIDTH-1:0]           pq_index,
  output logic [VALUE_WIDTH-1:0]           pq_write_value,
  input  logic [VALUE_WIDTH-1:0]           pq_read_value,
  input  logic [INDEX_WIDTH-1:0]           pq_min_index,
  input  logic [VALUE_WIDTH-1:0]           pq_min_value,
  output logic [INDEX_WIDTH*MAX_NODES-1:0] prev_vector_flattened
);

  localparam int unsigned NODE_W  = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
  localparam int unsigned COUNT_W = $clog2(MAX_NODES + 1);

  localparam logic [INDEX_WIDTH-1:0] UNVISITED  = '1;
  localparam logic [VALUE_WIDTH-1:0] INFINITY   = '1;
  localparam logic [INDEX_WIDTH-1:0] NODE_LIMIT = INDEX_WIDTH'(MAX_NODES);
  localparam logic [INDEX_WIDTH-1:0] LAST_NODE  = INDEX_WIDTH'(MAX_NODES - 1);
  localparam logic [COUNT_W-1:0]     POP_LIMIT  = COUNT_W'(MAX_NODES);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_INIT        = 3'd1;
  localparam logic [2:0] S_SELECT      = 3'd2;
  localparam logic [2:0] S_RELAX_ADDR  = 3'd3;
  localparam logic [2:0] S_RELAX_CHECK = 3'd4;
  localparam logic [2:0] S_DONE        = 3'd5;

  // Table row select; node indices are always below MAX_NODES here.
  function automatic logic [NODE_W-1:0] node_sel(input logic [INDEX_WIDTH-1:0] idx);
    return NODE_W'(idx);
  endfunction

  // ---------------------------------------------------------------------------
  // Registers and their next values
  // ---------------------------------------------------------------------------
  logic [2:0]                            state_q,     state_next;
  logic                                  busy_q,      busy_next;
  logic                                  done_q,      done_next;
  logic                                  pq_reset_q,  pq_reset_next;
  logic [INDEX_WIDTH-1:0]                pq_index_q,  pq_index_next;
  logic [INDEX_WIDTH-1:0]                edge_from_q, edge_from_next;
  logic [INDEX_WIDTH-1:0]                edge_to_q,   edge_to_next;
  logic [MAX_NODES-1:0][INDEX_WIDTH-1:0] prev_q,      prev_next;
  logic [MAX_NODES-1:0][INDEX_WIDTH-1:0] pred_q,      pred_next;
  logic [COUNT_W-1:0]                    pop_count_q, pop_count_next;
  logic [INDEX_WIDTH-1:0]                u_q,         u_next;
  logic [VALUE_WIDTH-1:0]                du_q,        du_next;
  logic [INDEX_WIDTH-1:0]                v_q,         v_next;
`ifdef DIJKSTRA_EARLY_EXIT_EN
  logic [INDEX_WIDTH-1:0]                target_q,    target_next;
`endif

  logic                   source_ok;
  logic [VALUE_WIDTH:0]   sum_wide;
  logic [VALUE_WIDTH-1:0] sum_sat;
  logic                   relax_hit;

  assign source_ok = (source < NODE_LIMIT);

  // Relaxation test for edge (u, v); the queue is indexed by v in RELAX_CHECK.
  always_comb begin
    sum_wide  = {1'b0, du_q} + {1'b0, edge_weight};
    sum_sat   = sum_wide[VALUE_WIDTH] ? INFINITY : sum_wide[VALUE_WIDTH-1:0];
    relax_hit = (state_q == S_RELAX_CHECK)
             && (prev_q[node_sel(v_q)] == UNVISITED)
             && (edge_weight != INFINITY)
             && (v_q != u_q)
             && (sum_sat < pq_read_value);
  end

  // The write strobe is decoded in the same cycle the weight and the current
  // distance arrive; gating with reset keeps the queue untouched in a reset cycle.
  assign pq_set_en      = relax_hit & reset;
  assign pq_write_value = sum_sat;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_q;
    busy_next      = busy_q;
    done_next      = done_q;
    pq_reset_next  = 1'b0;
    pq_index_next  = pq_index_q;
    edge_from_next = edge_from_q;
    edge_to_next   = edge_to_q;
    prev_next      = prev_q;
    pred_next      = pred_q;
    pop_count_next = pop_count_q;
    u_next         = u_q;
    du_next        = du_q;
    v_next         = v_q;
`ifdef DIJKSTRA_EARLY_EXIT_EN
    target_next    = target_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        // Out-of-range sources are dropped without leaving IDLE/DONE.
        if (start && source_ok) begin
          state_next    = S_INIT;
          busy_next     = 1'b1;
          done_next     = 1'b0;
          pq_reset_next = 1'b1;
          pq_index_next = source;
`ifdef DIJKSTRA_EARLY_EXIT_EN
          target_next   = target;
`endif
        end
      end

      S_INIT: begin
        // pq_index still holds the source while the queue is being loaded.
        prev_next                       = {MAX_NODES{UNVISITED}};
        pred_next                       = {MAX_NODES{UNVISITED}};
        pred_next[node_sel(pq_index_q)] = pq_index_q;
        pop_count_next                  = '0;
        state_next                      = S_SELECT;
      end

      S_SELECT: begin
        if ((pop_count_q == POP_LIMIT) || (pq_min_value == INFINITY)) begin
          state_next = S_DONE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end else begin
          // Publishing prev[u] here is what marks u visited for the queue.
          u_next                           = pq_min_index;
          du_next                          = pq_min_value;
          prev_next[node_sel(pq_min_index)] = pred_q[node_sel(pq_min_index)];
          pop_count_next                   = pop_count_q + COUNT_W'(1);
          v_next                           = '0;
          edge_from_next                   = pq_min_index;
          edge_to_next                     = '0;
          state_next                       = S_RELAX_ADDR;
`ifdef DIJKSTRA_EARLY_EXIT_EN
          if (pq_min_index == target_q) begin
            state_next = S_DONE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end
`endif
        end
      end

      S_RELAX_ADDR: begin
        // Adjacency read is in flight; point the queue at v for the compare.
        pq_index_next = v_q;
        state_next    = S_RELAX_CHECK;
      end

      S_RELAX_CHECK: begin
        if (relax_hit) begin
          pred_next[node_sel(v_q)] = u_q;
        end
        if (v_q == LAST_NODE) begin
          state_next = S_SELECT;
        end else begin
          v_next       = v_q + INDEX_WIDTH'(1);
          edge_to_next = v_q + INDEX_WIDTH'(1);
          state_next   = S_RELAX_ADDR;
        end
      end

      default: begin
        state_next = S_IDLE;
        busy_next  = 1'b0;
        done_next  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pq_reset_q  <= 1'b0;
      pq_index_q  <= '0;
      edge_from_q <= '0;
      edge_to_q   <= '0;
      prev_q      <= {MAX_NODES{UNVISITED}};
      pred_q      <= {MAX_NODES{UNVISITED}};
      pop_count_q <= '0;
      u_q         <= '0;
      du_q        <= '0;
      v_q         <= '0;
`ifdef DIJKSTRA_EARLY_EXIT_EN
      target_q    <= '0;
`endif
    end else begin
      state_q     <= state_next;
      busy_q      <= busy_next;
      done_q      <= done_next;
      pq_reset_q  <= pq_reset_next;
      pq_index_q  <= pq_index_next;
      edge_from_q <= edge_from_next;
      edge_to_q   <= edge_to_next;
      prev_q      <= prev_next;
      pred_q      <= pred_next;
      pop_count_q <= pop_count_next;
      u_q         <= u_next;
      du_q        <= du_next;
      v_q         <= v_next;
`ifdef DIJKSTRA_EARLY_EXIT_EN
      target_q    <= target_next;
`endif
    end
  end

  assign busy                  = busy_q;
  assign done                  = done_q;
  assign pq_reset              = pq_reset_q;
  assign pq_index              = pq_index_q;
  assign edge_from             = edge_from_q;
  assign edge_to               = edge_to_q;
  assign prev_vector_flattened = prev_q;

endmodule
